dcache_port_arbiter: RTL and testbench

- Shares one data-cache request port between NrPorts requesters. Default configuration: port 0 = load unit, port 1 = ZCMT table-jump fetch.
- Allows one outstanding transaction. The owner is locked from grant until its response returns.
- Sits between the requesters and the dcache, ahead of the data cache wrapper.
- Supports zero-latency forwarding in IDLE and round-robin fairness.

---
 rtl/dcache_arb_pkg.sv | 52 +++++
 rtl/dcache_port_arbiter_rr_arb_sel.sv | 23 ++
 rtl/dcache_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arb_pkg.sv
// Shared types and the round-robin search helper
// for the data-cache port arbiter.
package dcache_arb_pkg;

  localparam int unsigned MaxArbPorts = 8;
  localparam int unsigned PtrW = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } arb_state_e;

  typedef struct packed {
    logic [11:0] address_index;
    logic [19:0] address_tag;
    logic [31:0] data_wdata;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [1:0]  data_size;
    logic [3:0]  data_id;
    logic        kill_req;
    logic        tag_valid;
  } arb_req_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [3:0]  data_id;
    logic [31:0] data_rdata;
  } arb_rsp_t;

  // Returns {valid, index} of the first requester at or after ptr.
  function automatic logic [PtrW:0] rr_select(
    input logic [MaxArbPorts-1:0] req,
    input logic [PtrW-1:0]        ptr,
    input int unsigned            n
  );
    logic [PtrW:0] res;
    int unsigned   idx;
    res = '0;
    for (int unsigned i = 0; i < MaxArbPorts; i++) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !res[PtrW] && req[idx[PtrW-1:0]])
        res = {1'b1, idx[PtrW-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_rr_arb_sel.sv
// Combinational requester selector: first request
// found searching upward from i_ptr, with wrap.
module rr_arb_sel
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NrPorts = 2,
  localparam int unsigned IdxW =
    (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic [NrPorts-1:0] i_req,
  input  logic [IdxW-1:0]    i_ptr,
  output logic [IdxW-1:0]    o_sel,
  output logic               o_valid
);

  logic [PtrW:0] w_res;

  assign w_res = rr_select(MaxArbPorts'(i_req),
                           PtrW'(i_ptr), NrPorts);
  assign o_valid = w_res[PtrW];
  assign o_sel = IdxW'(w_res[PtrW-1:0]);

endmodule

// File: rtl/dcache_port_arbiter.sv
// One-outstanding dcache port arbiter, round-robin by default;
// define DCACHE_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter type dcache_req_i_t = arb_req_t,
  parameter type dcache_req_o_t = arb_rsp_t,
  parameter int unsigned NrPorts = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dcache_req_i_t req_ports_i [NrPorts],
  output dcache_req_o_t req_ports_o [NrPorts],
  output dcache_req_i_t mem_req_o,
  input  dcache_req_o_t mem_req_i,
  output logic          busy_o
);

  localparam int unsigned IdxW =
    (NrPorts > 1) ? $clog2(NrPorts) : 1;

  arb_state_e         r_state;
  logic [IdxW-1:0]    r_owner;
  logic [NrPorts-1:0] w_req;
  logic [IdxW-1:0]    w_ptr;
  logic [IdxW-1:0]    w_sel;
  logic [IdxW-1:0]    w_tgt;
  logic               w_valid;
  logic               w_gnt;
  logic               w_rvalid;
  dcache_req_i_t      w_mem;
  dcache_req_i_t      w_own;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < int'(NrPorts); i++)
      w_req[i] = req_ports_i[i].data_req;
  end

`ifdef DCACHE_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IdxW-1:0] r_rr_ptr;
  logic [IdxW-1:0] w_next;

  assign w_ptr = r_rr_ptr;
  assign w_next = (r_owner == IdxW'(NrPorts - 1))
                ? '0 : r_owner + 1'b1;
`endif

  rr_arb_sel #(
    .NrPorts(NrPorts)
  ) u_sel (
    .i_req  (w_req),
    .i_ptr  (w_ptr),
    .o_sel  (w_sel),
    .o_valid(w_valid)
  );

  always_comb begin
    w_own = req_ports_i[r_owner];
    w_mem = '0;
    w_tgt = r_owner;
    w_gnt = 1'b0;
    w_rvalid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_mem = req_ports_i[w_sel];
          w_tgt = w_sel;
          w_gnt = mem_req_i.data_gnt;
        end
      end
      WAIT_GNT: begin
        w_mem = w_own;
        w_gnt = mem_req_i.data_gnt & w_own.data_req;
      end
      WAIT_RVALID: begin
        w_mem.address_tag = w_own.address_tag;
        w_mem.tag_valid = w_own.tag_valid;
        w_mem.kill_req = w_own.kill_req;
        w_rvalid = mem_req_i.data_rvalid;
      end
      default: ;
    endcase
    if (!rst_ni) begin
      w_mem = '0;
      w_gnt = 1'b0;
      w_rvalid = 1'b0;
    end
  end

  assign mem_req_o = w_mem;
  assign busy_o = (r_state != IDLE);

  always_comb begin
    for (int p = 0; p < int'(NrPorts); p++) begin
      req_ports_o[p] = '0;
      req_ports_o[p].data_rdata = mem_req_i.data_rdata;
      req_ports_o[p].data_id = mem_req_i.data_id;
      if (IdxW'(p) == w_tgt) begin
        req_ports_o[p].data_gnt = w_gnt;
        req_ports_o[p].data_rvalid = w_rvalid;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_owner <= '0;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_owner <= w_sel;
            r_state <= mem_req_i.data_gnt
                     ? WAIT_RVALID : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (!w_own.data_req)
            r_state <= IDLE;
          else if (mem_req_i.data_gnt)
            r_state <= WAIT_RVALID;
        end
        WAIT_RVALID: begin
          // fairness pointer moves only on completion
          if (mem_req_i.data_rvalid) begin
            r_state <= IDLE;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
            r_rr_ptr <= w_next;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with a
// transaction-level reference model checked every cycle.
module tb_dcache_port_arbiter;
  import dcache_arb_pkg::*;

  localparam int N = 2;

  logic     clk = 1'b0;
  logic     rst_n;
  arb_req_t req [N];
  arb_rsp_t rsp_o [N];
  arb_req_t mem_o;
  arb_rsp_t mem_i;
  logic     busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.NrPorts(N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_ports_i(req),
    .req_ports_o(rsp_o),
    .mem_req_o  (mem_o),
    .mem_req_i  (mem_i),
    .busy_o     (busy)
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // model: one transaction in flight, phases
  // "waiting for accept" and "waiting for data"
  bit m_busy = 1'b0;
  bit m_acc = 1'b0;
  int m_own = 0;
  int m_next = 0;

  function automatic int pick();
    for (int i = 0; i < N; i++)
      if (req[(m_next + i) % N].data_req)
        return (m_next + i) % N;
    return -1;
  endfunction

  always @(posedge clk) begin : mdl
    int p;
    if (!rst_n) begin
      m_busy = 1'b0; m_acc = 1'b0;
      m_own = 0; m_next = 0;
    end else if (!m_busy) begin
      p = pick();
      if (p >= 0) begin
        m_busy = 1'b1; m_own = p;
        m_acc = mem_i.data_gnt;
      end
    end else if (!m_acc) begin
      if (!req[m_own].data_req) m_busy = 1'b0;
      else if (mem_i.data_gnt) m_acc = 1'b1;
    end else if (mem_i.data_rvalid) begin
      m_busy = 1'b0; m_acc = 1'b0;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
      m_next = (m_own + 1) % N;
`endif
    end
  end

  int glog[$];
  int n_busy = 0;
  int rvc [N];

  always @(negedge clk) begin : cmp
    arb_req_t     em;
    logic [N-1:0] eg, ev, ag, av;
    int           p;
    em = '0; eg = '0; ev = '0;
    if (rst_n) begin
      if (!m_busy) begin
        p = pick();
        if (p >= 0) begin
          em = req[p];
          eg[p] = mem_i.data_gnt;
        end
      end else if (!m_acc) begin
        em = req[m_own];
        eg[m_own] = mem_i.data_gnt & req[m_own].data_req;
      end else begin
        em.address_tag = req[m_own].address_tag;
        em.tag_valid = req[m_own].tag_valid;
        em.kill_req = req[m_own].kill_req;
        ev[m_own] = mem_i.data_rvalid;
      end
    end
    for (int i = 0; i < N; i++) begin
      ag[i] = rsp_o[i].data_gnt;
      av[i] = rsp_o[i].data_rvalid;
    end
    chk("mem_req", 128'(mem_o), 128'(em));
    chk("gnt_vec", 128'(ag), 128'(eg));
    chk("rvalid_vec", 128'(av), 128'(ev));
    chk("busy", 128'(busy), 128'(m_busy));
    for (int i = 0; i < N; i++) begin
      if (ev[i])
        chk("rdata", 128'(rsp_o[i].data_rdata),
            128'(mem_i.data_rdata));
      if (ag[i]) glog.push_back(i);
      if (av[i]) rvc[i]++;
    end
    if (busy) n_busy++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    for (int i = 0; i < N; i++) req[i] = '0;
    mem_i = '0;
  endtask

  task automatic clr_log();
    glog.delete();
    n_busy = 0;
    for (int i = 0; i < N; i++) rvc[i] = 0;
  endtask

  function automatic arb_req_t mk(input logic [11:0] ix,
                                  input logic [3:0] id);
    arb_req_t r;
    r = '0;
    r.address_index = ix;
    r.address_tag = {8'h0, ix};
    r.data_req = 1'b1;
    r.data_be = 4'hf;
    r.data_size = 2'd2;
    r.data_id = id;
    r.tag_valid = 1'b1;
    return r;
  endfunction

  function automatic int gat(input int i);
    return (glog.size() > i) ? glog[i] : -1;
  endfunction

  int exp2 [4];

  initial begin
    rst_n = 1'b0;
    clr_in();
    clr_log();
    tick(); tick();
    rst_n = 1'b1;
    #3;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_dreq", 128'(mem_o.data_req), 128'(0));
    tick();

    // single request on port 1
    clr_log();
    req[1] = mk(12'h104, 4'h3);
    mem_i.data_gnt = 1'b1;
    #3 chk("t1_fwd_idx", 128'(mem_o.address_index), 128'(12'h104));
    tick();
    req[1].data_req = 1'b0;
    mem_i.data_gnt = 1'b0;
    tick(); tick();
    mem_i.data_rvalid = 1'b1;
    mem_i.data_rdata = 32'h8000_0040;
    #3;
    chk("t1_rv1", 128'(rsp_o[1].data_rvalid), 128'(1));
    chk("t1_rd1", 128'(rsp_o[1].data_rdata), 128'(32'h8000_0040));
    chk("t1_rv0", 128'(rsp_o[0].data_rvalid), 128'(0));
    tick();
    clr_in();
    tick();
    chk("t1_busy_cyc", 128'(n_busy), 128'(3));
    chk("t1_rvc1", 128'(rvc[1]), 128'(1));
    chk("t1_rvc0", 128'(rvc[0]), 128'(0));

    // both ports request back to back
    clr_log();
    req[0] = mk(12'h010, 4'h1);
    req[1] = mk(12'h020, 4'h2);
    mem_i.data_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mem_i.data_rvalid = k[0];
      mem_i.data_rdata = 32'h100 + k;
      tick();
    end
    clr_in();
    tick();
`ifdef DCACHE_ARB_FIXED_PRIO_EN
    exp2 = '{0, 0, 0, 0};
`else
    exp2 = '{0, 1, 0, 1};
`endif
    chk("t2_ngnt", 128'(glog.size()), 128'(4));
    for (int i = 0; i < 4; i++)
      chk("t2_order", 128'(gat(i)), 128'(exp2[i]));

    // grant stall on port 0, port 1 queued behind it
    clr_log();
    req[0] = mk(12'h200, 4'h4);
    tick(); tick();
    req[1] = mk(12'h300, 4'h5);
    #3 chk("t3_lock", 128'(mem_o.address_index), 128'(12'h200));
    tick(); tick();
    mem_i.data_gnt = 1'b1;
    tick();
    mem_i.data_gnt = 1'b0;
    req[0].data_req = 1'b0;
    mem_i.data_rvalid = 1'b1;
    #3 chk("t3_rv0", 128'(rsp_o[0].data_rvalid), 128'(1));
    tick();
    mem_i.data_rvalid = 1'b0;
    mem_i.data_gnt = 1'b1;
    #3;
    chk("t3_idx1", 128'(mem_o.address_index), 128'(12'h300));
    chk("t3_gnt1", 128'(rsp_o[1].data_gnt), 128'(1));
    tick();
    req[1].data_req = 1'b0;
    mem_i.data_gnt = 1'b0;
    mem_i.data_rvalid = 1'b1;
    tick();
    clr_in();
    tick();
    chk("t3_ngnt", 128'(glog.size()), 128'(2));
    chk("t3_g0", 128'(gat(0)), 128'(0));
    chk("t3_g1", 128'(gat(1)), 128'(1));

    // kill_req from owner while waiting for data
    clr_log();
    req[0] = mk(12'h700, 4'h6);
    mem_i.data_gnt = 1'b1;
    tick();
    mem_i.data_gnt = 1'b0;
    req[0].data_req = 1'b0;
    req[0].kill_req = 1'b1;
    #3;
    chk("t5_kill", 128'(mem_o.kill_req), 128'(1));
    chk("t5_dreq", 128'(mem_o.data_req), 128'(0));
    tick();
    mem_i.data_rvalid = 1'b1;
    mem_i.data_rdata = 32'hdead_beef;
    #3 chk("t5_rv0", 128'(rsp_o[0].data_rvalid), 128'(1));
    tick();
    clr_in();
    #3 chk("t5_idle", 128'(busy), 128'(0));
    tick();

    // port 1 withdraws before grant
    clr_log();
    req[1] = mk(12'h400, 4'h7);
    tick();
    req[1].data_req = 1'b0;
    tick();
    #3 chk("t4_idle", 128'(busy), 128'(0));
    chk("t4_nognt", 128'(glog.size()), 128'(0));
    req[0] = mk(12'h500, 4'h8);
    req[1] = mk(12'h600, 4'h9);
    mem_i.data_gnt = 1'b1;
    #1;
`ifdef DCACHE_ARB_FIXED_PRIO_EN
    chk("t4_next", 128'(mem_o.address_index), 128'(12'h500));
`else
    chk("t4_next", 128'(mem_o.address_index), 128'(12'h600));
`endif
    tick();
    clr_in();
    mem_i.data_rvalid = 1'b1;
    tick();
    clr_in();
    tick();

    // reset while waiting for data, late rvalid afterwards
    req[0] = mk(12'h010, 4'h1);
    mem_i.data_gnt = 1'b1;
    tick();
    clr_in();
    mem_i.data_rvalid = 1'b1;
    tick();
    clr_in();
    req[1] = mk(12'h020, 4'h2);
    mem_i.data_gnt = 1'b1;
    tick();
    clr_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clr_log();
    mem_i.data_rvalid = 1'b1;
    mem_i.data_rdata = 32'h1234_5678;
    #3;
    chk("t6_rv0", 128'(rsp_o[0].data_rvalid), 128'(0));
    chk("t6_rv1", 128'(rsp_o[1].data_rvalid), 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));
    tick();
    mem_i = '0;
    req[0] = mk(12'h0a0, 4'ha);
    req[1] = mk(12'h0b0, 4'hb);
    mem_i.data_gnt = 1'b1;
    #3;
    chk("t6_gnt0", 128'(rsp_o[0].data_gnt), 128'(1));
    chk("t6_gnt1", 128'(rsp_o[1].data_gnt), 128'(0));
    tick();
    clr_in();
    mem_i.data_rvalid = 1'b1;
    tick();
    clr_in();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
